// File: rtl/hex_scroll_pkg.sv
// Shared types and constants for the 7-segment scroll sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hex_scroll_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_LEFT   = 2'b01,
        MODE_RIGHT  = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam int         NUM_DIGITS = 8;

    // Counter must hold the longest period, 7 rate units.
    function automatic int tick_width(input int step_cycles);
        return $clog2(7 * step_cycles + 1);
    endfunction

    // 26 bits for the 50 MHz / 100 ms rate unit.
    localparam int TICK_W = tick_width(5_000_000);

endpackage

// File: rtl/hex_tick_gen.sv
// Animation tick generator: one-cycle step every rate*STEP_CYCLES cycles.
// Latency: first step rate*STEP_CYCLES cycles after clr or a rate change.
// Backpressure: none; rate 0 holds the counter at 0 and keeps step low.
module hex_tick_gen
    import hex_scroll_pkg::*;
#(
    parameter int STEP_CYCLES = 5_000_000,
    parameter int CNT_W       = TICK_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] rate,
    input  logic       clr,
    output logic       step
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] period_m1;

    // Last count value of the current period; unused when rate is 0.
    always_comb begin
        period_m1 = CNT_W'(int'(rate) * STEP_CYCLES - 1);
    end

    assign step = (rate != 3'd0) && !clr && (cnt_q == period_m1);

    // Count cycles within the period, restarting on step, clear or pause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || (rate == 3'd0) || step) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Eight-digit 7-segment sequencer: pattern buffer, rotate/blink animation, registered outputs.
// Latency: write or step in cycle t is visible on seg0..seg7 in cycle t+1.
// Backpressure: none; writes always accepted. HEX_SCROLL_BLINK_EN enables blink mode 11.
module hex_scroll_ctrl
    import hex_scroll_pkg::*;
#(
    parameter int STEP_CYCLES = 5_000_000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [1:0] modes,
    input  logic [2:0] rotation,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] seg0,
    output logic [7:0] seg1,
    output logic [7:0] seg2,
    output logic [7:0] seg3,
    output logic [7:0] seg4,
    output logic [7:0] seg5,
    output logic [7:0] seg6,
    output logic [7:0] seg7,
    output logic       step
);

    logic [1:0] mode_s1, mode_s2, mode_prev;
    logic [2:0] rate_s1, rate_s2, rate_prev;
    logic       mode_chg, rate_chg;
    mode_e      mode_eff;

    logic [2:0] off_q, off_n;
    logic       phase_n;
    logic [7:0] pat_q [NUM_DIGITS];
    logic [7:0] pat_n [NUM_DIGITS];
    logic [7:0] seg_q [NUM_DIGITS];
    logic [7:0] seg_n [NUM_DIGITS];

    // Two-flop synchronizers on the switches, plus a copy for edge detection.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mode_s1   <= '0;
            mode_s2   <= '0;
            mode_prev <= '0;
            rate_s1   <= '0;
            rate_s2   <= '0;
            rate_prev <= '0;
        end else begin
            mode_s1   <= modes;
            mode_s2   <= mode_s1;
            mode_prev <= mode_s2;
            rate_s1   <= rotation;
            rate_s2   <= rate_s1;
            rate_prev <= rate_s2;
        end
    end

    assign mode_chg = (mode_s2 != mode_prev);
    assign rate_chg = (rate_s2 != rate_prev);

    // Mode 11 folds onto static when blink support is compiled out.
    always_comb begin
`ifdef HEX_SCROLL_BLINK_EN
        mode_eff = mode_e'(mode_s2);
`else
        mode_eff = (mode_e'(mode_s2) == MODE_BLINK) ? MODE_STATIC : mode_e'(mode_s2);
`endif
    end

    hex_tick_gen #(
        .STEP_CYCLES (STEP_CYCLES),
        .CNT_W       (tick_width(STEP_CYCLES))
    ) u_tick (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .rate  (rate_s2),
        .clr   (mode_chg || rate_chg),
        .step  (step)
    );

    // Next display offset; static pins it to 0, blink holds it.
    always_comb begin
        off_n = off_q;
        case (mode_eff)
            MODE_STATIC: off_n = 3'd0;
            MODE_LEFT:   if (step) off_n = off_q + 3'd1;
            MODE_RIGHT:  if (step) off_n = off_q - 3'd1;
            default:     off_n = off_q;
        endcase
    end

`ifdef HEX_SCROLL_BLINK_EN
    logic phase_q;

    // Blink phase toggles per step in blink mode, otherwise parked at "visible".
    always_comb begin
        phase_n = 1'b1;
        if (!mode_chg && (mode_eff == MODE_BLINK)) begin
            phase_n = step ? ~phase_q : phase_q;
        end
    end

    // Blink phase register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            phase_q <= 1'b1;
        end else begin
            phase_q <= phase_n;
        end
    end
`else
    assign phase_n = 1'b1;
`endif

    // Buffer after this cycle's write, then the rotated/blanked digit view of it.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            pat_n[i] = pat_q[i];
        end
        if (wr_en) begin
            pat_n[wr_addr] = wr_data;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg_n[i] = phase_n ? pat_n[3'(i) + off_n] : SEG_BLANK;
        end
    end

    // Buffer, offset and output registers; outputs use next-state so t+1 latency holds.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            off_q <= 3'd0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                pat_q[i] <= SEG_BLANK;
                seg_q[i] <= SEG_BLANK;
            end
        end else begin
            off_q <= off_n;
            pat_q <= pat_n;
            seg_q <= seg_n;
        end
    end

    assign seg0 = seg_q[0];
    assign seg1 = seg_q[1];
    assign seg2 = seg_q[2];
    assign seg3 = seg_q[3];
    assign seg4 = seg_q[4];
    assign seg5 = seg_q[5];
    assign seg6 = seg_q[6];
    assign seg7 = seg_q[7];

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Self-checking bench for hex_scroll_ctrl with a 4-cycle rate unit.
// Latency: n/a.
// Backpressure: n/a.
module tb_hex_scroll_ctrl;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] modes;
    logic [2:0] rotation;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
    logic       step;
    logic [7:0] segs [8];

    int total = 0;
    int bad   = 0;

    hex_scroll_ctrl #(.STEP_CYCLES(SC)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .modes         (modes),
        .rotation      (rotation),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .seg0          (seg0),
        .seg1          (seg1),
        .seg2          (seg2),
        .seg3          (seg3),
        .seg4          (seg4),
        .seg5          (seg5),
        .seg6          (seg6),
        .seg7          (seg7),
        .step          (step)
    );

    always #5 clk = ~clk;

    assign segs[0] = seg0;
    assign segs[1] = seg1;
    assign segs[2] = seg2;
    assign segs[3] = seg3;
    assign segs[4] = seg4;
    assign segs[5] = seg5;
    assign segs[6] = seg6;
    assign segs[7] = seg7;

    // Reference model: switch values delayed two samples, a schedule of the
    // next step by absolute cycle number, and the display as a rotated buffer.
    int         cyc, due;
    logic [1:0] m1, ms, mp;
    logic [2:0] r1, rs, rp;
    logic [2:0] m_off;
    logic       m_phase;
    logic [7:0] m_buf [8];

    function automatic bit exp_step();
        return (rs != 3'd0) && (ms == mp) && (rs == rp) && (cyc == due);
    endfunction

    function automatic logic [63:0] exp_pack();
        logic [63:0] p;
        for (int n = 0; n < 8; n++)
            p[n*8 +: 8] = m_phase ? m_buf[(n + int'(m_off)) % 8] : 8'hFF;
        return p;
    endfunction

    function automatic logic [63:0] dut_pack();
        logic [63:0] p;
        for (int n = 0; n < 8; n++) p[n*8 +: 8] = segs[n];
        return p;
    endfunction

    task automatic model_reset();
        cyc = 0; due = 0;
        m1 = 0; ms = 0; mp = 0; r1 = 0; rs = 0; rp = 0;
        m_off = 0; m_phase = 1'b1;
        for (int n = 0; n < 8; n++) m_buf[n] = 8'hFF;
    endtask

    task automatic model_edge();
        bit stp;
        bit mchg;
        int m;
        stp  = exp_step();
        mchg = (ms != mp);
        m    = int'(ms);
`ifndef HEX_SCROLL_BLINK_EN
        if (m == 3) m = 0;
`endif
        if (wr_en) m_buf[wr_addr] = wr_data;
        if (m == 0) m_off = 0;
        else if (m == 1 && stp) m_off = m_off + 3'd1;
        else if (m == 2 && stp) m_off = m_off - 3'd1;
        if (mchg || m != 3) m_phase = 1'b1;
        else if (stp) m_phase = ~m_phase;
        if (mchg || (rs != rp) || stp) due = cyc + SC * int'(rs);
        mp = ms; ms = m1; m1 = modes;
        rp = rs; rs = r1; r1 = rotation;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    // Advance one clock, update the model, then compare the whole output state.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        chk("cycle_segs", dut_pack(), exp_pack());
        chk("cycle_step", 64'(step), 64'(exp_step()));
    endtask

    task automatic wait_step(input int lim, output int n);
        n = 0;
        while (n < lim) begin
            tick();
            n++;
            if (step) return;
        end
        total++;
        bad++;
        $display("FAIL step_timeout got=no step want=step within %0d cycles", lim);
    endtask

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
        int         idx;
        logic [7:0] exp;
        int         nb_idx;
        logic [7:0] nb_exp;
    } wvec_t;

    wvec_t tbl [8];
    int    n;
    int    cnt;
    int    exp_idx;

    initial begin
        tbl[0] = '{3'd0, 8'h01, 0, 8'h01, 1, 8'hFF};
        tbl[1] = '{3'd1, 8'h02, 1, 8'h02, 2, 8'hFF};
        tbl[2] = '{3'd2, 8'h03, 2, 8'h03, 3, 8'hFF};
        tbl[3] = '{3'd3, 8'h04, 3, 8'h04, 4, 8'hFF};
        tbl[4] = '{3'd4, 8'h05, 4, 8'h05, 5, 8'hFF};
        tbl[5] = '{3'd5, 8'h06, 5, 8'h06, 6, 8'hFF};
        tbl[6] = '{3'd6, 8'h07, 6, 8'h07, 7, 8'hFF};
        tbl[7] = '{3'd7, 8'h08, 7, 8'h08, 0, 8'h01};

        modes = 0; rotation = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) tick();
        #2 rst_n = 1'b1;
        repeat (3) tick();
        chk("reset_segs", dut_pack(), {8{8'hFF}});
        chk("reset_step", 64'(step), 64'd0);

        // Static-mode writes, one per record.
        for (int i = 0; i < 8; i++) begin
            wr_en = 1; wr_addr = tbl[i].addr; wr_data = tbl[i].data;
            tick();
            wr_en = 0;
            chk("write_seg", 64'(segs[tbl[i].idx]), 64'(tbl[i].exp));
            chk("write_neighbour", 64'(segs[tbl[i].nb_idx]), 64'(tbl[i].nb_exp));
        end

        // Rotate left, rate 1.
        modes = 2'b01; rotation = 3'd1;
        wait_step(40, n);
        chk("left_first_latency", 64'(n), 64'd6);
        tick();
        chk("left_seg0", 64'(seg0), 64'h02);
        chk("left_seg7", 64'(seg7), 64'h01);
        wait_step(40, n);
        chk("left_period", 64'(n), 64'd3);
        repeat (6) wait_step(40, n);
        tick();
        chk("left_wrap8", dut_pack(), 64'h0807060504030201);

        // Rotate right, rate 2.
        modes = 2'b10; rotation = 3'd2;
        wait_step(60, n);
        chk("right_first_latency", 64'(n), 64'd10);
        tick();
        chk("right_seg0", 64'(seg0), 64'h08);
        chk("right_seg1", 64'(seg1), 64'h01);
        wait_step(60, n);
        chk("right_period", 64'(n), 64'd7);

        // Pause mid-rotation, then write while frozen.
        rotation = 3'd0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (step) cnt++;
        end
        chk("freeze_steps", 64'(cnt), 64'd0);
        chk("freeze_segs", dut_pack(), 64'h0605040302010807);
        wr_en = 1; wr_addr = 3'd3; wr_data = 8'h7F;
        tick();
        wr_en = 0;
        chk("freeze_write", 64'(seg5), 64'h7F);

        // Mode 11, rate 1.
        modes = 2'b11; rotation = 3'd1;
        wait_step(40, n);
        chk("blink_first_latency", 64'(n), 64'd6);
        tick();
`ifdef HEX_SCROLL_BLINK_EN
        chk("blink_off_phase", dut_pack(), {8{8'hFF}});
`else
        chk("mode3_static_a", dut_pack(), 64'h080706057F030201);
`endif
        wait_step(40, n);
        chk("blink_period", 64'(n), 64'd3);
        tick();
`ifdef HEX_SCROLL_BLINK_EN
        chk("blink_on_phase", dut_pack(), 64'h06057F0302010807);
`else
        chk("mode3_static_b", dut_pack(), 64'h080706057F030201);
`endif

        // Write coinciding with a step.
        modes = 2'b01; rotation = 3'd1;
        wait_step(40, n);
        wr_en = 1; wr_addr = 3'd2; wr_data = 8'hA5;
        tick();
        wr_en = 0;
`ifdef HEX_SCROLL_BLINK_EN
        exp_idx = 3;
`else
        exp_idx = 1;
`endif
        chk("write_and_step", 64'(segs[exp_idx]), 64'hA5);

        // Asynchronous reset mid-rotation.
        repeat (5) tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_reset_segs", dut_pack(), {8{8'hFF}});
        chk("async_reset_step", 64'(step), 64'd0);
        repeat (2) tick();
        #2 rst_n = 1'b1;
        tick();
        wr_en = 1; wr_addr = 3'd0; wr_data = 8'h3C;
        tick();
        wr_en = 0;
        chk("post_reset_off0", 64'(seg0), 64'h3C);
        chk("post_reset_seg1", 64'(seg1), 64'hFF);
        wait_step(40, n);
        chk("post_reset_first_step", 64'(n), 64'd4);

        // Randomized traffic against the model.
        for (int it = 0; it < 2000; it++) begin
            if ($urandom_range(0, 39) == 0) modes = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) rotation = 3'($urandom_range(0, 2));
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 8'($urandom_range(0, 255));
            tick();
        end
        wr_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_scroll_ctrl.md
# hex_scroll_ctrl

Sequencer for the eight active-low 7-segment digits driven from the Nios system. Holds an 8-entry pattern buffer written by the processor-side port and drives all eight digits from it. The board switches select static, rotate-left, rotate-right or blink mode and the step rate, so the CPU only loads patterns and never times the animation. The block sits between the system's PIO write path and the HEX0–HEX7 pins.

## Interface
- STEP_CYCLES, 5_000_000: clock cycles per rate unit; 100 ms at 50 MHz.
- clk_clk  in  1  system clock, 50 MHz.
- reset_reset_n  in  1  asynchronous, active-low reset.
- modes  in  2  raw switch input: 00 static, 01 rotate left, 10 rotate right, 11 blink.
- rotation  in  3  raw switch input: step period in rate units; 0 pauses.
- wr_en  in  1  buffer write strobe, one cycle.
- wr_addr  in  3  buffer entry index.
- wr_data  in  8  segment pattern, active-low.
- seg0..seg7  out  8 each  digit outputs, registered.
- step  out  1  one-cycle pulse on each animation step.

## Operation
- Both `modes` and `rotation` pass through a 2-flop synchronizer. All logic uses the synchronized values.
- Pattern buffer `buf[0..7]`, 8 bits per entry.
  - `wr_en` writes `buf[wr_addr] <= wr_data`.
  - Writes are accepted in every mode and every state.
- Tick generator:
  - When `rotation` is nonzero, counts `rotation*STEP_CYCLES` cycles, then pulses `step` and restarts from 0.
  - When `rotation` is 0, the counter holds at 0 and `step` stays low.
- 3-bit display offset `off`:
  - Static mode forces `off` to 0.
  - Rotate left: `off <= off+1` on each step, mod 8.
  - Rotate right: `off <= off-1` on each step, mod 8.
  - Blink mode holds `off` unchanged.
- Blink mode: flag `phase` toggles on each step.
  - When `phase` is 0, all segN are 8'hFF (blank).
  - When `phase` is 1, segN shows `buf[(N+off) mod 8]`.
- All other modes: `segN = buf[(N+off) mod 8]`. `phase` is held at 1.
- Mode change: when the synchronized `modes` value differs from its previous-cycle value, the tick counter clears to 0 and `phase` sets to 1. `off` is kept, except that entering static clears it.
- Rate change: when the synchronized `rotation` value changes, the tick counter clears to 0. No step is generated on that cycle.

## Timing
- Reset values:
  - `buf[*]` = 8'hFF; seg0..seg7 = 8'hFF.
  - `off` = 0, `phase` = 1, `step` = 0, tick counter = 0, synchronizers = 0.
- Write latency: an entry written in cycle t appears on the affected segN in cycle t+1.
- Step latency: `step` is high in cycle t, and the new `off`/`phase` is visible on segN in cycle t+1.
- Simultaneous write and step in the same cycle: both take effect. The output in t+1 uses the new data and the new offset.
- Switch latency: a switch edge affects behaviour 2 cycles after it is sampled by the synchronizer.
- Offset wrap: 7+1 gives 0 and 0−1 gives 7, with no glitch cycle.
- Reset asserted mid-animation: all state returns to reset values asynchronously. The first step after release comes `rotation*STEP_CYCLES` cycles after the synchronized value is valid.
- Tick counter width is 26 bits, which covers the worst case 7×5_000_000. Widths for other STEP_CYCLES values follow from the product.

## Configuration
- HEX_SCROLL_BLINK_EN
  - Defined: mode 11 is blink, as described above.
  - Undefined: mode 11 behaves exactly like static. The `phase` logic is removed and `phase` is tied to 1.

## Structure
- Package `hex_scroll_pkg` holds:
  - The mode enum (MODE_STATIC, MODE_LEFT, MODE_RIGHT, MODE_BLINK).
  - SEG_BLANK = 8'hFF and NUM_DIGITS = 8.
  - The tick counter width constant.
- Sub-module `hex_tick_gen` contains the tick generator: synchronized rate in, clear in, one-cycle `step` out.
- The top level contains the buffer, offset/phase registers and the output mux.

## Test plan
Bench uses STEP_CYCLES=4.
1. Reset, then write 0x01..0x08 to addr 0..7 in static mode → seg0=0x01 … seg7=0x08 one cycle after each write. Before any write, all segs are 0xFF.
2. Mode 01, rotation 1 → `step` every 4 cycles. After 1 step, seg0=0x02 and seg7=0x01. After 8 steps, the display is back to its original order.
3. Mode 10, rotation 2 → `step` every 8 cycles. After 1 step, seg0=0x08 and seg1=0x01.
4. Mode 11, rotation 1 → outputs alternate between all 0xFF and the pattern every 4 cycles. With HEX_SCROLL_BLINK_EN undefined, the pattern is held steadily.
5. Set rotation to 0 mid-rotate → `step` stays low and the display is frozen. Write addr 3 = 0x7F while frozen → the digit showing buf[3] updates next cycle.
6. Write and step in the same cycle, then assert reset mid-rotation → the next-cycle output reflects both the new data and the new offset. After reset, all segs are 0xFF and `off` = 0.
